// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                loader: FSM state encoding, byte/word geometry and the
//                width of the header word-count field.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int HDR_BYTES      = 2;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Assembles a byte stream into little-endian words. Byte k of
//                a word lands in bits [8k+7:8k]. The completed word and a
//                one-cycle word_valid pulse appear the cycle after the final
//                byte of the word is accepted.
//  Ports       : clk_i       - clock
//                rst_i       - asynchronous active-low reset
//                in_valid    - a byte is consumed this cycle
//                in_data     - byte value
//                word_last   - combinational: this byte completes a word
//                word_valid  - registered completion pulse
//                word_data   - registered completed word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = BYTES_PER_WORD * 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              word_last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic [BYTE_IDX_W-1:0] byte_idx;
    // Lower bytes of the word in progress; the top byte goes straight
    // into word_data together with these.
    logic [WORD_W-9:0]     acc;

    assign word_last = in_valid && (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            byte_idx   <= '0;
            acc        <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= word_last;
            if (in_valid) begin
                byte_idx <= byte_idx + 1'b1;  // wraps 3 -> 0 at word end
                for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                    if (byte_idx == BYTE_IDX_W'(k)) begin
                        acc[8*k +: 8] <= in_data;
                    end
                end
            end
            if (word_last) begin
                word_data <= {in_data, acc};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Byte-stream program loader. Receives a 2-byte word count N
//                (LSB first), then 4*N payload bytes, packs them into 32-bit
//                little-endian words written to instruction memory from
//                address 0, then raises cpu_start_o/done_o. An N larger than
//                the memory depth aborts the load (err_o).
//  Config      : CHECKSUM_EN - when defined, a trailing byte equal to the XOR
//                of all header and payload bytes is required; a mismatch
//                aborts to the error state without starting the CPU.
//  Ports       : clk_i, rst_i (async active-low)
//                byte_valid_i/byte_data_i/byte_ready_o - byte stream in
//                imem_we_o/imem_addr_o/imem_data_o     - memory write port
//                cpu_start_o, done_o, err_o            - status
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              cpu_start_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(1) << ADDR_W;

    state_t             state;
    state_t             state_nx;
    logic               ready_st;
    logic               xfer;
    logic [7:0]         cnt_lo;
    logic [CNT_W-1:0]   hdr_n;
    logic [CNT_W-1:0]   word_total;
    logic [CNT_W-1:0]   word_idx;
    logic [ADDR_W-1:0]  addr_q;
    logic               pack_in;
    logic               word_last;
    logic               word_valid;
    logic               final_word;
`ifdef CHECKSUM_EN
    logic [7:0]         csum;
`endif

    assign xfer       = byte_valid_i && byte_ready_o;
    assign hdr_n      = {byte_data_i, cnt_lo};
    assign pack_in    = xfer && (state == DATA);
    assign final_word = word_last && ((word_idx + 1'b1) == word_total);

    byte_packer #(
        .WORD_W     (DATA_W)
    ) u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid   (pack_in),
        .in_data    (byte_data_i),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_data  (imem_data_o)
    );

    assign imem_we_o   = word_valid;
    assign imem_addr_o = addr_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= HDR0;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            HDR0: if (xfer) state_nx = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (hdr_n == '0)                    state_nx = RUN;
                    else if ({1'b0, hdr_n} > MAX_WORDS) state_nx = ERR;
                    else                                state_nx = DATA;
                end
            end
            DATA: begin
`ifdef CHECKSUM_EN
                if (final_word) state_nx = CSUM;
`else
                if (final_word) state_nx = RUN;
`endif
            end
            CSUM: begin
`ifdef CHECKSUM_EN
                if (xfer) state_nx = (byte_data_i == csum) ? RUN : ERR;
`else
                state_nx = ERR;
`endif
            end
            RUN:     state_nx = RUN;
            ERR:     state_nx = ERR;
            default: state_nx = HDR0;
        endcase
    end

    // Output logic. RUN is entered on the edge that also launches the final
    // write, so start/done are held back while that write pulse is still up.
    always_comb begin
        ready_st    = (state == HDR0) || (state == HDR1) ||
                      (state == DATA) || (state == CSUM);
        byte_ready_o = ready_st && rst_i;
        cpu_start_o  = (state == RUN) && !word_valid;
        done_o       = (state == RUN) && !word_valid;
        err_o        = (state == ERR);
    end

    // Header capture, word index and write address
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_lo     <= '0;
            word_total <= '0;
            word_idx   <= '0;
            addr_q     <= '0;
        end else begin
            if (xfer && (state == HDR0)) cnt_lo     <= byte_data_i;
            if (xfer && (state == HDR1)) word_total <= hdr_n;
            if (word_last) begin
                addr_q   <= word_idx[ADDR_W-1:0];
                word_idx <= word_idx + 1'b1;
            end
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            csum <= '0;
        end else if (xfer && (state != CSUM)) begin
            csum <= csum ^ byte_data_i;
        end
    end
`endif

endmodule
`default_nettype wire
